// File: rtl/spdif_pkg.sv
// Shared constants, run classes and helpers for the S/PDIF biphase-mark receiver.
package spdif_pkg;

    localparam int UI_CLKS   = 3;
    localparam int SHORT_MAX = UI_CLKS + 1;
    localparam int MID_MAX   = 2 * UI_CLKS + 1;
    localparam int LONG_MAX  = 3 * UI_CLKS + 1;
    localparam int RUN_W     = $clog2(LONG_MAX + 2);

    localparam int SLOT_FIRST = 4;
    localparam int SLOT_LAST  = 31;
    localparam int NBITS      = SLOT_LAST - SLOT_FIRST + 1;

    localparam logic [2:0] FLAG_B = 3'b001;
    localparam logic [2:0] FLAG_M = 3'b010;
    localparam logic [2:0] FLAG_W = 3'b100;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef logic [RUN_W-1:0] run_cnt_t;

    typedef enum logic [1:0] {
        RUN_S   = 2'd0,
        RUN_M   = 2'd1,
        RUN_L   = 2'd2,
        RUN_ERR = 2'd3
    } run_class_e;

    localparam run_cnt_t RUN_SAT = run_cnt_t'(LONG_MAX + 1);

    function automatic run_class_e classify_run(input run_cnt_t n);
        run_class_e c;
        if (n < run_cnt_t'(2))               c = RUN_ERR;
        else if (n <= run_cnt_t'(SHORT_MAX)) c = RUN_S;
        else if (n <= run_cnt_t'(MID_MAX))   c = RUN_M;
        else if (n <= run_cnt_t'(LONG_MAX))  c = RUN_L;
        else                                 c = RUN_ERR;
        return c;
    endfunction

endpackage

// File: rtl/spdif_run_meter.sv
// Synchronises spdif_in, detects transitions and classes the run that each
// transition ends as 1/2/3 UI or error.
module spdif_run_meter
    import spdif_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spdif_in,
    output logic       run_edge,
    output run_class_e run_class
);

    logic [2:0] sync_q, sync_d;
    run_cnt_t   cnt_q, cnt_d;

    // sync_q[1] is the synchronised input; sync_q[2] is its one-clk-old copy.
    always_comb begin
        sync_d    = {sync_q[1:0], spdif_in};
        run_edge  = sync_q[1] ^ sync_q[2];
        run_class = classify_run(cnt_q);
        cnt_d     = cnt_q;
        if (run_edge) begin
            cnt_d = run_cnt_t'(1);
        end else if (cnt_q != RUN_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spdif_rx_core.sv
// S/PDIF subframe decoder: preamble lock, biphase data decode, output strobe.
// Optional build macro PARITY_CHECK_EN drops subframes with odd parity.
module spdif_rx_core
    import spdif_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spdif_in,
    output logic [2:0]  flag,
    output logic        enable,
    output logic [24:0] bfr
);

    logic       run_edge;
    run_class_e run_class;

    spdif_run_meter u_run_meter (
        .clk       (clk),
        .rst_n     (rst_n),
        .spdif_in  (spdif_in),
        .run_edge  (run_edge),
        .run_class (run_class)
    );

    localparam logic [4:0] LAST_BIT = 5'(NBITS - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       pre_idx_q, pre_idx_d;
    run_class_e       first_q, first_d;
    logic [2:0]       code_q, code_d;
    logic             half_q, half_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [NBITS-2:0] shreg_q, shreg_d;
    logic [2:0]       flag_q, flag_d;
    logic [24:0]      bfr_q, bfr_d;
    logic             enable_q, enable_d;

    logic abort, take_bit, bit_val, commit;

    always_comb begin
        state_d   = state_q;
        pre_idx_d = pre_idx_q;
        first_d   = first_q;
        code_d    = code_q;
        half_d    = half_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        flag_d    = flag_q;
        bfr_d     = bfr_q;
        enable_d  = 1'b0;
        abort     = 1'b0;
        take_bit  = 1'b0;
        bit_val   = 1'b0;
        commit    = 1'b0;

        if (run_edge) begin
            case (state_q)
                ST_HUNT: begin
                    if (run_class == RUN_L) begin
                        state_d   = ST_PRE;
                        pre_idx_d = 2'd0;
                    end
                end
                ST_PRE: begin
                    pre_idx_d = pre_idx_q + 2'd1;
                    if (pre_idx_q == 2'd0) begin
                        first_d = run_class;
                        abort   = (run_class == RUN_ERR);
                    end else if (pre_idx_q == 2'd1) begin
                        abort = (run_class != RUN_S);
                    end else begin
                        state_d   = ST_DATA;
                        half_d    = 1'b0;
                        bit_cnt_d = 5'd0;
                        // Polarity-free match on run lengths after the leading 3 UI.
                        if (first_q == RUN_S && run_class == RUN_L)      code_d = FLAG_B;
                        else if (first_q == RUN_L && run_class == RUN_S) code_d = FLAG_M;
                        else if (first_q == RUN_M && run_class == RUN_M) code_d = FLAG_W;
                        else                                             abort  = 1'b1;
                    end
                end
                ST_DATA: begin
                    case (run_class)
                        RUN_S: begin
                            if (half_q) begin
                                take_bit = 1'b1;
                                bit_val  = 1'b1;
                            end else begin
                                half_d = 1'b1;
                            end
                        end
                        RUN_M: begin
                            if (half_q) abort    = 1'b1;
                            else        take_bit = 1'b1;
                        end
                        default: abort = 1'b1;
                    endcase
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (take_bit) begin
            half_d    = 1'b0;
            shreg_d   = {bit_val, shreg_q[NBITS-2:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == LAST_BIT) begin
                state_d = ST_HUNT;
`ifdef PARITY_CHECK_EN
                commit = ~(^{bit_val, shreg_q});
`else
                commit = 1'b1;
`endif
            end
        end

        // shreg_q holds slots 4..30 with slot 4 at bit 0 when slot 31 arrives.
        if (commit) begin
            flag_d   = code_q;
            bfr_d    = shreg_q[24:0];
            enable_d = 1'b1;
        end

        // A 3-UI run that breaks a subframe is the start of the next preamble.
        if (abort) begin
            if (run_class == RUN_L) begin
                state_d   = ST_PRE;
                pre_idx_d = 2'd0;
            end else begin
                state_d = ST_HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            pre_idx_q <= 2'd0;
            first_q   <= RUN_S;
            code_q    <= 3'b000;
            half_q    <= 1'b0;
            bit_cnt_q <= 5'd0;
            shreg_q   <= '0;
            flag_q    <= 3'b000;
            bfr_q     <= 25'd0;
            enable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_idx_q <= pre_idx_d;
            first_q   <= first_d;
            code_q    <= code_d;
            half_q    <= half_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            flag_q    <= flag_d;
            bfr_q     <= bfr_d;
            enable_q  <= enable_d;
        end
    end

    assign flag   = flag_q;
    assign bfr    = bfr_q;
    assign enable = enable_q;

endmodule

// File: tb/tb_spdif_rx_core.sv
// Bench for spdif_rx_core: builds biphase-mark subframes run by run and
// scores each enable strobe against an expected {flag, bfr} queue.
module tb_spdif_rx_core;
    import spdif_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spdif_in;
    logic [2:0]  flag;
    logic        enable;
    logic [24:0] bfr;

    spdif_rx_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spdif_in (spdif_in),
        .flag     (flag),
        .enable   (enable),
        .bfr      (bfr)
    );

    always #5 clk = ~clk;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          n_strobes = 0;
    logic [27:0] exp_q[$];
    logic [27:0] last_exp  = '0;
    logic        prev_en   = 1'b0;
    int          noise[10] = '{1, 2, 1, 1, 2, 1, 2, 2, 1, 1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Each run starts with a transition and lasts n clocks.
    task automatic run_clks(input int n);
        spdif_in = ~spdif_in;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_ui(input int n);
        run_clks(n * UI_CLKS);
    endtask

    task automatic send_subframe(input logic [2:0] pre, input logic [23:0] audio,
                                 input logic v, input logic [1:0] uc, input logic p_flip,
                                 input int cut_at, input logic glitch, input logic expect_strobe);
        logic [27:0] slots;
        logic        p;
        p     = (^{uc, v, audio}) ^ p_flip;
        slots = {p, uc[1], uc[0], v, audio};
        if (expect_strobe) exp_q.push_back({pre, v, audio});
        run_ui(3);
        if (pre == FLAG_B) begin
            run_ui(1); run_ui(1); run_ui(3);
        end else if (pre == FLAG_M) begin
            run_ui(3); run_ui(1); run_ui(1);
        end else begin
            run_ui(2); run_ui(1); run_ui(2);
        end
        for (int i = 0; i < 28; i++) begin
            if (i == cut_at) begin
                if (glitch) run_clks(12);
                return;
            end
            if (slots[i]) begin
                run_ui(1);
                run_ui(1);
            end else begin
                run_ui(2);
            end
        end
    endtask

    task automatic tail();
        repeat (4) run_ui(1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (enable) begin
                n_strobes++;
                check("en_single", 32'(prev_en), 32'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(enable), 32'(0));
                end else begin
                    last_exp = exp_q.pop_front();
                    check("flag", 32'(flag), 32'(last_exp[27:25]));
                    check("bfr", 32'(bfr), 32'(last_exp[24:0]));
                end
            end
            prev_en = enable;
        end else begin
            prev_en = 1'b0;
        end
    end

    initial begin
        int          saved;
        logic [2:0]  rp;
        rst_n    = 1'b0;
        spdif_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            spdif_in = ~spdif_in;
        end
        check("reset_flag", 32'(flag), 32'(0));
        check("reset_enable", 32'(enable), 32'(0));
        check("reset_bfr", 32'(bfr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (noise[i]) run_ui(noise[i]);
        send_subframe(FLAG_M, 24'hA5A5A5, 1'b0, 2'b00, 1'b0, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_m");

        send_subframe(FLAG_B, 24'h000001, 1'b1, 2'b00, 1'b0, -1, 1'b0, 1'b1);
        send_subframe(FLAG_W, 24'h800000, 1'b1, 2'b00, 1'b0, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_bw");

        run_ui(1);
        send_subframe(FLAG_B, 24'hFFFFFF, 1'b0, 2'b00, 1'b0, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_inv");

        saved = n_strobes;
        send_subframe(FLAG_W, 24'h123456, 1'b1, 2'b01, 1'b0, 10, 1'b1, 1'b0);
        tail();
        repeat (10) @(negedge clk);
        check("glitch_no_strobe", 32'(n_strobes), 32'(saved));
        check("glitch_hold_flag", 32'(flag), 32'(last_exp[27:25]));
        check("glitch_hold_bfr", 32'(bfr), 32'(last_exp[24:0]));
        send_subframe(FLAG_B, 24'h0F0F0F, 1'b0, 2'b10, 1'b0, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_after_glitch");

        for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 2))
                0:       rp = FLAG_B;
                1:       rp = FLAG_M;
                default: rp = FLAG_W;
            endcase
            send_subframe(rp, 24'($urandom), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'b0, -1, 1'b0, 1'b1);
        end
        tail();
        wait_drain("drain_random");

        saved = n_strobes;
`ifdef PARITY_CHECK_EN
        send_subframe(FLAG_M, 24'h00003C, 1'b0, 2'b00, 1'b1, -1, 1'b0, 1'b0);
        tail();
        repeat (10) @(negedge clk);
        check("parity_no_strobe", 32'(n_strobes), 32'(saved));
        check("parity_hold_flag", 32'(flag), 32'(last_exp[27:25]));
        check("parity_hold_bfr", 32'(bfr), 32'(last_exp[24:0]));
`else
        send_subframe(FLAG_M, 24'h00003C, 1'b0, 2'b00, 1'b1, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_parity");
        check("parity_strobe", 32'(n_strobes), 32'(saved + 1));
`endif

        saved = n_strobes;
        send_subframe(FLAG_M, 24'h111111, 1'b1, 2'b00, 1'b0, 12, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_flag", 32'(flag), 32'(0));
        check("midreset_enable", 32'(enable), 32'(0));
        check("midreset_bfr", 32'(bfr), 32'(0));
        check("midreset_no_strobe", 32'(n_strobes), 32'(saved));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_subframe(FLAG_W, 24'h5A5A5A, 1'b0, 2'b11, 1'b0, -1, 1'b0, 1'b1);
        tail();
        wait_drain("drain_after_reset");

        check("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
